// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer ahead of the decode path.
// Issues one word fetch at a time over a req/ack handshake, buffers
// returned {inst, pc} pairs in a DEPTH-entry FIFO and presents the head
// to the core with valid/ready. A redirect flushes the buffer and
// restarts fetch at the new PC.
//
// Ports:
//   clock, reset        : clock, asynchronous active-low reset
//   mem_req, mem_addr   : registered fetch request / word-aligned address
//   mem_ack, mem_rdata  : memory completion and returned instruction
//   inst_valid/inst/inst_pc, inst_ready : head of queue to the core
//   redirect, redirect_pc : flush and restart fetch
//   occupancy           : current number of buffered entries
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       mem_req,
  output logic [63:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [63:0]                inst_pc,
  input  logic                       inst_ready,
  input  logic                       redirect,
  input  logic [63:0]                redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][31:0] q_inst;
  logic [DEPTH-1:0][63:0] q_pc;
  logic [AW-1:0]          head, tail;
  logic [CW-1:0]          count;
  logic [63:0]            fetch_pc;
  logic                   drop;

  logic          complete, push, pop;
  logic [CW-1:0] count_next;
  logic          drop_next;
  logic [63:0]   eff_pc;
  logic          issue;

  assign complete = mem_req & mem_ack;
  assign push     = complete & ~drop & ~redirect;
  assign pop      = inst_valid & inst_ready & ~redirect;

  // Outputs depend on registered state only.
  assign inst_valid = (count != '0);
  assign inst       = q_inst[head];
  assign inst_pc    = q_pc[head];
  assign occupancy  = count;

  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    drop_next  = drop;
    eff_pc     = fetch_pc;
    if (complete && drop) drop_next = 1'b0;
    if (redirect) begin
      count_next = '0;
      // A request still in flight at redirect time returns stale data;
      // remember to throw it away when it completes.
      drop_next  = mem_req & ~mem_ack;
      eff_pc     = redirect_pc & ~64'd3;
    end
    // A pending request is never withdrawn; otherwise issue when the
    // response is guaranteed a free slot.
    issue = ~(mem_req & ~complete) && (count_next < CW'(DEPTH)) && ~drop_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_inst   <= '0;
      q_pc     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      if (push) begin
        q_inst[tail] <= mem_rdata;
        q_pc[tail]   <= mem_addr;
      end
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
      end
      count    <= count_next;
      drop     <= drop_next;
      fetch_pc <= eff_pc;
      if (mem_req && !complete) begin
        mem_req <= 1'b1;
      end else if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= eff_pc;
        fetch_pc <= eff_pc + 64'd4;
      end else begin
        mem_req <= 1'b0;
      end
    end
  end
endmodule
